// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor speed regulator: FSM encoding,
// datapath widths and the signed clamp used by the integrator and output stage.
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_INTEG = 3'd2,
        ST_MULT  = 3'd3,
        ST_SUM   = 3'd4
    } state_t;

    localparam int ERR_W = 17;
    localparam int INT_W = 24;
    localparam int ACC_W = 33;

    function automatic logic signed [ACC_W-1:0] clamp_s(
        input logic signed [ACC_W-1:0] val,
        input logic signed [ACC_W-1:0] lo,
        input logic signed [ACC_W-1:0] hi
    );
        logic signed [ACC_W-1:0] res;
        if (val < lo) begin
            res = lo;
        end else if (val > hi) begin
            res = hi;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// PWM generator: free-running period counter with a duty shadow register that
// only reloads at the period wrap, so a duty change never truncates a pulse.
module motor_pwm_gen #(
    parameter int unsigned PWM_PERIOD = 1000,
    parameter int unsigned DUTY_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] CNT_ONE  = DUTY_W'(1);

    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_applied;
    logic              r_pwm;
    logic [DUTY_W-1:0] w_cnt_nxt;
    logic [DUTY_W-1:0] w_applied_nxt;

    // next counter value and shadow reload at the wrap
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_applied_nxt = r_applied;
        if (r_cnt == CNT_LAST) begin
            w_cnt_nxt     = '0;
            w_applied_nxt = duty;
        end else begin
            w_cnt_nxt     = r_cnt + CNT_ONE;
            w_applied_nxt = r_applied;
        end
    end

    // counter, shadow duty and pre-computed compare result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_applied <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_applied <= w_applied_nxt;
            r_pwm     <= (w_cnt_nxt < w_applied_nxt);
        end
    end

    // enable gates the drive immediately, without waiting for a clock edge
    assign pwm = enable & r_pwm;

endmodule

// File: rtl/motor_speed_ctrl.sv
// Closed-loop PI speed regulator: a five-state sequence turns each measured
// window count into a clamped PWM duty, which motor_pwm_gen drives out.
module motor_speed_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = 1000,
    parameter int unsigned DUTY_W     = 10,
    parameter int unsigned KP         = 16,
    parameter int unsigned KI         = 2,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned INT_LIM    = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [15:0]       target_cnt,
    input  logic [15:0]       edge_cnt,
    input  logic              meas_valid,
    output logic [DUTY_W-1:0] duty_out,
    output logic              pwm_out,
    output logic              busy,
    output logic              sat_flag,
    output logic              ovr_flag
);

    localparam logic signed [ACC_W-1:0] KP_S      = ACC_W'(KP);
    localparam logic signed [ACC_W-1:0] KI_S      = ACC_W'(KI);
    localparam logic signed [ACC_W-1:0] PERIOD_S  = ACC_W'(PWM_PERIOD);
    localparam logic signed [ACC_W-1:0] INT_LIM_S = ACC_W'(INT_LIM);
    localparam logic signed [ACC_W-1:0] ACC_ZERO  = '0;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [15:0]              r_tgt;
    logic [15:0]              r_meas;
    logic signed [ERR_W-1:0]  r_err;
    logic signed [INT_W-1:0]  r_integ;
    logic signed [ACC_W-1:0]  r_p;
    logic signed [ACC_W-1:0]  r_i;
    logic [DUTY_W-1:0]        r_duty;
    logic                     r_sat;
    logic                     r_ovr;
    logic                     r_busy;

    logic signed [ERR_W-1:0]  w_err;
    logic signed [ACC_W-1:0]  w_err_ext;
    logic signed [ACC_W-1:0]  w_integ_ext;
    logic signed [ACC_W-1:0]  w_integ_sum;
    logic signed [ACC_W-1:0]  w_p;
    logic signed [ACC_W-1:0]  w_i;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_u;
    logic                     w_sat;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; a low enable always forces IDLE, even over a strobe
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (meas_valid) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ERR:   w_state_nxt = ST_INTEG;
                ST_INTEG: w_state_nxt = ST_MULT;
                ST_MULT:  w_state_nxt = ST_SUM;
                ST_SUM:   w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // PI arithmetic, all widened to the accumulator width before combining
    always_comb begin
        w_err       = $signed({1'b0, r_tgt}) - $signed({1'b0, r_meas});
        w_err_ext   = {{(ACC_W-ERR_W){r_err[ERR_W-1]}}, r_err};
        w_integ_ext = {{(ACC_W-INT_W){r_integ[INT_W-1]}}, r_integ};
        w_integ_sum = w_integ_ext + w_err_ext;
        w_p         = w_err_ext * KP_S;
        w_i         = w_integ_ext * KI_S;
        w_sum       = r_p + r_i;
        w_u         = w_sum >>> SHIFT;
        w_sat       = (w_u < ACC_ZERO) || (w_u > PERIOD_S);
    end

    // sample capture and pipeline registers, stepped by the FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt   <= '0;
            r_meas  <= '0;
            r_err   <= '0;
            r_integ <= '0;
            r_p     <= '0;
            r_i     <= '0;
            r_duty  <= '0;
            r_sat   <= 1'b0;
        end else if (!enable) begin
            r_err   <= '0;
            r_integ <= '0;
            r_p     <= '0;
            r_i     <= '0;
            r_duty  <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (meas_valid) begin
                        r_tgt  <= target_cnt;
                        r_meas <= edge_cnt;
                    end
                end
                ST_ERR:   r_err   <= w_err;
                ST_INTEG: r_integ <= INT_W'(clamp_s(w_integ_sum, -INT_LIM_S, INT_LIM_S));
                ST_MULT: begin
                    r_p <= w_p;
                    r_i <= w_i;
                end
                ST_SUM: begin
                    // a zero target means "stop": no drive and no wind-up carried over
                    if (r_tgt == 16'd0) begin
                        r_duty  <= '0;
                        r_sat   <= 1'b0;
                        r_integ <= '0;
                    end else begin
                        r_duty  <= DUTY_W'(clamp_s(w_u, ACC_ZERO, PERIOD_S));
                        r_sat   <= w_sat;
                    end
                end
                default: begin
                    r_err <= '0;
                end
            endcase
        end
    end

    // busy and sticky overrun status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_ovr  <= 1'b0;
        end else if (!enable) begin
            r_busy <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (meas_valid && (r_state != ST_IDLE)) begin
                r_ovr <= 1'b1;
            end
        end
    end

    motor_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_W     (DUTY_W)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .duty   (r_duty),
        .pwm    (pwm_out)
    );

    assign duty_out = r_duty;
    assign busy     = r_busy;
    assign sat_flag = r_sat;
    assign ovr_flag = r_ovr;

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Self-checking bench for motor_speed_ctrl: a PI reference model pushes the
// expected duty/saturation per strobe and results are popped when busy drops.
module tb_motor_speed_ctrl;

    localparam int KP_M     = 16;
    localparam int KI_M     = 2;
    localparam int SHIFT_M  = 4;
    localparam int PERIOD_M = 1000;
    localparam int LIM_M    = 65535;

    typedef struct {
        int duty;
        int sat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] target_cnt;
    logic [15:0] edge_cnt;
    logic        meas_valid;
    logic [9:0]  duty_out;
    logic        pwm_out;
    logic        busy;
    logic        sat_flag;
    logic        ovr_flag;

    int     n_checks = 0;
    int     n_errors = 0;
    longint m_integ  = 0;
    exp_t   sb_q[$];
    int     runs[$];
    int     run_len  = 0;
    bit     mon_on   = 1'b0;

    motor_speed_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .target_cnt (target_cnt),
        .edge_cnt   (edge_cnt),
        .meas_valid (meas_valid),
        .duty_out   (duty_out),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .sat_flag   (sat_flag),
        .ovr_flag   (ovr_flag)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // measure lengths of contiguous high pulses on pwm_out
    always @(negedge clk) begin
        if (mon_on) begin
            if (pwm_out === 1'b1) begin
                run_len++;
            end else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int tgt, input int meas);
        longint err;
        longint u;
        exp_t   e;
        err = longint'(tgt) - longint'(meas);
        if (tgt == 0) begin
            m_integ = 0;
            e.duty  = 0;
            e.sat   = 0;
        end else begin
            m_integ = m_integ + err;
            if (m_integ > LIM_M)  m_integ = LIM_M;
            if (m_integ < -LIM_M) m_integ = -LIM_M;
            u = (KP_M * err + KI_M * m_integ) >>> SHIFT_M;
            e.sat  = (u < 0 || u > PERIOD_M) ? 1 : 0;
            e.duty = (u < 0) ? 0 : ((u > PERIOD_M) ? PERIOD_M : int'(u));
        end
        sb_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_duty"}, duty_out, e.duty);
            check_eq({tag, "_sat"}, sat_flag, e.sat);
        end
    endtask

    task automatic strobe(input string tag, input int tgt, input int meas);
        int n;
        push_expect(tgt, meas);
        target_cnt = 16'(tgt);
        edge_cnt   = 16'(meas);
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 10);
        check_eq({tag, "_latency"}, n, 4);
        pop_compare(tag);
    endtask

    task automatic disable_cycle();
        enable = 1'b0;
        tick();
        enable  = 1'b1;
        m_integ = 0;
        tick();
    endtask

    task automatic count_high(output int highs);
        highs = 0;
        for (int k = 0; k < PERIOD_M; k++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    task automatic wait_pwm(input logic level, input string tag);
        int n;
        n = 0;
        while (pwm_out !== level && n < 2100) begin
            tick();
            n++;
        end
        if (n >= 2100) check_eq({tag, "_timeout"}, pwm_out, level);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        int n;
        rst = 1'b1; enable = 1'b0; meas_valid = 1'b0;
        target_cnt = 16'd0; edge_cnt = 16'd0;
        repeat (3) tick();
        check_eq("rst_duty", duty_out, 0);
        check_eq("rst_pwm", pwm_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sat", sat_flag, 0);
        check_eq("rst_ovr", ovr_flag, 0);
        rst = 1'b0;
        tick();
        enable = 1'b1;
        tick();

        // basic PI steps: duty 11 then 12 as the integrator grows
        strobe("pi1", 100, 90);
        strobe("pi2", 100, 90);
        check_eq("pi_ovr", ovr_flag, 0);

        // saturation high and full-period drive
        disable_cycle();
        strobe("sat_hi", 1000, 0);
        repeat (PERIOD_M + 1) tick();
        count_high(highs);
        check_eq("sat_hi_pwm_highs", highs, PERIOD_M);
        enable = 1'b0;
        #1;
        check_eq("dis_pwm_immediate", pwm_out, 0);
        tick();
        check_eq("dis_duty", duty_out, 0);
        check_eq("dis_sat", sat_flag, 0);
        enable  = 1'b1;
        m_integ = 0;
        tick();

        // saturation low
        strobe("sat_lo", 50, 200);
        repeat (PERIOD_M + 1) tick();
        count_high(highs);
        check_eq("sat_lo_pwm_highs", highs, 0);

        // overrun: second strobe two cycles later is dropped
        disable_cycle();
        push_expect(100, 90);
        target_cnt = 16'd100; edge_cnt = 16'd90; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        tick();
        target_cnt = 16'd100; edge_cnt = 16'd0; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        check_eq("ovr_set", ovr_flag, 1);
        n = 3;
        while (busy && n < 12) begin
            tick();
            n++;
        end
        check_eq("ovr_latency", n, 5);
        pop_compare("ovr");
        enable = 1'b0;
        tick();
        check_eq("ovr_clear", ovr_flag, 0);
        check_eq("ovr_dis_duty", duty_out, 0);
        enable  = 1'b1;
        m_integ = 0;
        tick();

        // zero target forces duty 0 and clears the integrator
        strobe("tz_pre", 100, 90);
        strobe("tz_zero", 0, 5);
        strobe("tz_post", 100, 90);

        // disable and strobe in the same cycle: no capture
        target_cnt = 16'd100; edge_cnt = 16'd0;
        enable = 1'b0; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0; enable = 1'b1;
        m_integ = 0;
        check_eq("dwin_busy", busy, 0);
        tick();
        check_eq("dwin_busy2", busy, 0);
        check_eq("dwin_duty", duty_out, 0);

        // glitch-free duty change 200 -> 800 during a high pulse
        strobe("gf_200", 178, 0);
        repeat (PERIOD_M + 1) tick();
        wait_pwm(1'b0, "gf_low");
        runs.delete();
        run_len = 0;
        mon_on  = 1'b1;
        wait_pwm(1'b1, "gf_rise");
        repeat (100) tick();
        strobe("gf_800", 692, 0);
        repeat (2200) tick();
        mon_on = 1'b0;
        check_eq("gf_runs_count_ok", (runs.size() >= 2) ? 1 : 0, 1);
        if (runs.size() >= 2) begin
            check_eq("gf_run0", runs[0], 200);
            check_eq("gf_run1", runs[1], 800);
        end

        // asynchronous reset in the middle of a high pulse
        wait_pwm(1'b1, "rst_mid");
        check_eq("pre_rst_pwm", pwm_out, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_duty", duty_out, 0);
        check_eq("mid_rst_pwm", pwm_out, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_sat", sat_flag, 0);
        tick();
        rst = 1'b0;
        m_integ = 0;
        tick();
        check_eq("post_rst_busy", busy, 0);
        strobe("post_rst", 100, 90);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
